regfile_wb_arbiter: RTL and testbench

Write-back arbiter in front of the 32×64 integer register file. It accepts results from two producers, the single-cycle ALU path and the multi-cycle load unit, over valid/ready handshakes, and buffers each in a small FIFO. Each cycle it commits at most one write through the register file's single `write_enable`/`waddr`/`wdata` port. It also exports a pending-write mask that issue logic uses to hold hazards.

---
 rtl/core_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 63 ++++++
 rtl/regfile_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types for the write-back path: register-file geometry, write-back
// source identifiers and the {rd, data} request record.
package core_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_MEM = 1'b1
   } wb_src_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
      return NUM_REGS'(1) << rd;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular-buffer FIFO for one write-back source. Exposes per-entry tag/valid
// views so the owner can build a hazard mask over everything still buffered.
module wb_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 69,
   parameter  int TAG_W = 5,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      head,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH-1:0]      entry_valid,
   output logic [TAG_W-1:0]      entry_tag [DEPTH]
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Slot i is live when its distance from the read pointer is below the count.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entry_valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count);
         entry_tag[i]   = mem_q[i][WIDTH-1 -: TAG_W];
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: buffers ALU and load results, commits one per cycle to the
// register file and exports a pending-write mask. WB_ROUND_ROBIN_EN selects round-robin.
module regfile_wb_arbiter
   import core_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int XLEN  = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [XLEN-1:0]       mem_data,
   output logic                  write_enable,
   output logic [REG_ADDR_W-1:0] waddr,
   output logic [XLEN-1:0]       wdata,
   output logic [NUM_REGS-1:0]   pending_mask
);

   localparam int ENT_W = REG_ADDR_W + XLEN;

   logic [ENT_W-1:0]      alu_head, mem_head, grant_head;
   logic                  alu_full, mem_full, alu_empty, mem_empty;
   logic [DEPTH-1:0]      alu_ent_valid, mem_ent_valid;
   logic [REG_ADDR_W-1:0] alu_ent_rd [DEPTH];
   logic [REG_ADDR_W-1:0] mem_ent_rd [DEPTH];
   logic                  alu_push, mem_push, alu_pop, mem_pop;
   logic                  grant_valid;
   wb_src_e               grant_src;

   assign alu_ready = !alu_full;
   assign mem_ready = !mem_full;

   // rd==0 transfers complete the handshake but are never buffered.
   assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
   assign mem_push = mem_valid && mem_ready && (mem_rd != '0);

   wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W), .TAG_W(REG_ADDR_W)) u_alu_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (alu_push),
      .push_data   ({alu_rd, alu_data}),
      .pop         (alu_pop),
      .head        (alu_head),
      .full        (alu_full),
      .empty       (alu_empty),
      .entry_valid (alu_ent_valid),
      .entry_tag   (alu_ent_rd)
   );

   wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W), .TAG_W(REG_ADDR_W)) u_mem_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (mem_push),
      .push_data   ({mem_rd, mem_data}),
      .pop         (mem_pop),
      .head        (mem_head),
      .full        (mem_full),
      .empty       (mem_empty),
      .entry_valid (mem_ent_valid),
      .entry_tag   (mem_ent_rd)
   );

`ifdef WB_ROUND_ROBIN_EN
   wb_src_e rr_prio;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_prio <= WB_SRC_ALU;
      end else if (grant_valid) begin
         rr_prio <= (grant_src == WB_SRC_ALU) ? WB_SRC_MEM : WB_SRC_ALU;
      end
   end
`endif

   always_comb begin
      grant_valid = !alu_empty || !mem_empty;
      grant_src   = WB_SRC_ALU;
      if (!alu_empty && !mem_empty) begin
`ifdef WB_ROUND_ROBIN_EN
         grant_src = rr_prio;
`else
         grant_src = WB_SRC_MEM;
`endif
      end else if (!mem_empty) begin
         grant_src = WB_SRC_MEM;
      end
   end

   assign alu_pop    = grant_valid && (grant_src == WB_SRC_ALU);
   assign mem_pop    = grant_valid && (grant_src == WB_SRC_MEM);
   assign grant_head = (grant_src == WB_SRC_MEM) ? mem_head : alu_head;

   // Address/data hold their last value when idle; only the strobe drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_enable <= 1'b0;
         waddr        <= '0;
         wdata        <= '0;
      end else begin
         write_enable <= grant_valid;
         if (grant_valid) begin
            waddr <= grant_head[ENT_W-1 -: REG_ADDR_W];
            wdata <= grant_head[XLEN-1:0];
         end
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (alu_ent_valid[i]) pending_mask |= rd_onehot(alu_ent_rd[i]);
         if (mem_ent_valid[i]) pending_mask |= rd_onehot(mem_ent_rd[i]);
      end
      if (write_enable) pending_mask |= rd_onehot(waddr);
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_regfile_wb_arbiter;

   localparam int DEPTH = 2;
   localparam int XLEN  = 64;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            alu_valid = 1'b0, mem_valid = 1'b0;
   logic [4:0]      alu_rd = '0, mem_rd = '0;
   logic [XLEN-1:0] alu_data = '0, mem_data = '0;
   logic            alu_ready, mem_ready, write_enable;
   logic [4:0]      waddr;
   logic [XLEN-1:0] wdata;
   logic [31:0]     pending_mask;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_rd       (mem_rd),
      .mem_data     (mem_data),
      .write_enable (write_enable),
      .waddr        (waddr),
      .wdata        (wdata),
      .pending_mask (pending_mask)
   );

   // Reference model: one queue per source plus the staged write.
   logic [68:0]     aq[$];
   logic [68:0]     mq[$];
   logic            m_we;
   logic [4:0]      m_waddr;
   logic [XLEN-1:0] m_wdata;
   int              m_prio;     // 0: ALU favoured on the next tie, 1: load unit
   bit              last_a_acc, last_m_acc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      aq.delete();
      mq.delete();
      m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_prio = 0;
      last_a_acc = 1'b0; last_m_acc = 1'b0;
   endtask

   function automatic logic [31:0] model_mask();
      logic [31:0] m = '0;
      foreach (aq[i]) m[aq[i][68:64]] = 1'b1;
      foreach (mq[i]) m[mq[i][68:64]] = 1'b1;
      if (m_we) m[m_waddr] = 1'b1;
      return m;
   endfunction

   task automatic model_step();
      int  g;
      bit  a_acc, m_acc;
      a_acc = alu_valid && (aq.size() != DEPTH);
      m_acc = mem_valid && (mq.size() != DEPTH);
      g = -1;
      if (aq.size() > 0 && mq.size() > 0) begin
`ifdef WB_ROUND_ROBIN_EN
         g = m_prio;
`else
         g = 1;
`endif
      end else if (aq.size() > 0) g = 0;
      else if (mq.size() > 0) g = 1;
      m_we = (g >= 0);
      if (g == 0) begin
         {m_waddr, m_wdata} = aq.pop_front();
         m_prio = 1;
      end else if (g == 1) begin
         {m_waddr, m_wdata} = mq.pop_front();
         m_prio = 0;
      end
      if (a_acc && alu_rd != 0) aq.push_back({alu_rd, alu_data});
      if (m_acc && mem_rd != 0) mq.push_back({mem_rd, mem_data});
      last_a_acc = a_acc;
      last_m_acc = m_acc;
   endtask

   task automatic check_all();
      chk("write_enable", 64'(write_enable), 64'(m_we));
      chk("waddr", 64'(waddr), 64'(m_waddr));
      chk("wdata", wdata, m_wdata);
      chk("pending_mask", 64'(pending_mask), 64'(model_mask()));
      chk("alu_ready", 64'(alu_ready), 64'(aq.size() != DEPTH));
      chk("mem_ready", 64'(mem_ready), 64'(mq.size() != DEPTH));
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; mem_valid = 1'b0;
      alu_rd = '0; mem_rd = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_all();
   endtask

   logic [4:0] commits[$];
   logic [4:0] exp_commits[8];
   int ai, mi, run, max_run, we_cnt;

   initial begin
      model_reset();

      // Reset state
      #2;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_write_enable", 64'(write_enable), 64'd0);
      chk("rst_pending_mask", 64'(pending_mask), 64'd0);
      chk("rst_alu_ready", 64'(alu_ready), 64'd1);
      chk("rst_mem_ready", 64'(mem_ready), 64'd1);

      // Single ALU result rd=5
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
      cyc();
      idle_inputs();
      chk("single_mask_buffered", 64'(pending_mask), 64'h20);
      chk("single_we_early", 64'(write_enable), 64'd0);
      cyc();
      chk("single_we", 64'(write_enable), 64'd1);
      chk("single_waddr", 64'(waddr), 64'd5);
      chk("single_wdata", wdata, 64'h1234);
      chk("single_mask_staged", 64'(pending_mask), 64'h20);
      cyc();
      chk("single_mask_clear", 64'(pending_mask), 64'd0);
      chk("single_we_off", 64'(write_enable), 64'd0);

      // x0 filter on the load path
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 64'hdead;
      chk("x0_mem_ready", 64'(mem_ready), 64'd1);
      cyc();
      idle_inputs();
      chk("x0_mask", 64'(pending_mask), 64'd0);
      cyc();
      chk("x0_we", 64'(write_enable), 64'd0);
      chk("x0_mask_after", 64'(pending_mask), 64'd0);

      // Contention: ALU rd 1..4 against load rd 11..14
`ifdef WB_ROUND_ROBIN_EN
      exp_commits = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
`else
      exp_commits = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd1, 5'd2, 5'd3, 5'd4};
`endif
      do_reset();
      ai = 0; mi = 0;
      commits.delete();
      for (int k = 0; k < 40 && commits.size() < 8; k++) begin
         alu_valid = (ai < 4); alu_rd = 5'(ai + 1); alu_data = 64'($urandom);
         mem_valid = (mi < 4); mem_rd = 5'(mi + 11); mem_data = 64'($urandom);
         cyc();
         if (last_a_acc) ai++;
         if (last_m_acc) mi++;
         if (write_enable === 1'b1) commits.push_back(waddr);
      end
      idle_inputs();
      chk("contend_commit_count", 64'(commits.size()), 64'd8);
      for (int k = 0; k < 8 && k < commits.size(); k++)
         chk($sformatf("contend_order_%0d", k), 64'(commits[k]), 64'(exp_commits[k]));

      // ALU backed up behind a streaming load source
      do_reset();
      ai = 0; mi = 0;
      for (int k = 0; k < 20; k++) begin
         alu_valid = (ai < 3); alu_rd = 5'(ai + 1); alu_data = 64'($urandom);
         mem_valid = (mi < 6); mem_rd = 5'(mi + 20); mem_data = 64'($urandom);
         cyc();
         if (last_a_acc) ai++;
         if (last_m_acc) mi++;
      end
      idle_inputs();
      chk("backpressure_alu_accepts", 64'(ai), 64'd3);

      // Asynchronous reset with writes buffered and staged
      do_reset();
      for (int k = 0; k < 2; k++) begin
         alu_valid = 1'b1; alu_rd = 5'(6 + k); alu_data = 64'($urandom);
         mem_valid = 1'b1; mem_rd = 5'(8 + k); mem_data = 64'($urandom);
         cyc();
      end
      idle_inputs();
      chk("pre_reset_buffered", 64'(aq.size() + mq.size()), 64'd3);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_we", 64'(write_enable), 64'd0);
      chk("async_rst_mask", 64'(pending_mask), 64'd0);
      cyc();
      #3;
      rst_n = 1'b1;
      we_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         cyc();
         if (write_enable !== 1'b0) we_cnt++;
      end
      chk("post_reset_no_write", 64'(we_cnt), 64'd0);

      // Back-to-back ALU stream of 8
      do_reset();
      run = 0; max_run = 0; we_cnt = 0;
      for (int k = 0; k < 11; k++) begin
         alu_valid = (k < 8); alu_rd = 5'(k + 1); alu_data = 64'($urandom);
         if (k < 8) chk($sformatf("stream_ready_%0d", k), 64'(alu_ready), 64'd1);
         cyc();
         if (write_enable === 1'b1) begin
            we_cnt++; run++;
            if (run > max_run) max_run = run;
         end else run = 0;
      end
      idle_inputs();
      chk("stream_commits", 64'(we_cnt), 64'd8);
      chk("stream_consecutive", 64'(max_run), 64'd8);

      // Random traffic
      do_reset();
      for (int k = 0; k < 400; k++) begin
         alu_valid = ($urandom_range(0, 3) != 0);
         mem_valid = ($urandom_range(0, 2) == 0);
         alu_rd = 5'($urandom_range(0, 31));
         mem_rd = 5'($urandom_range(0, 31));
         alu_data = {32'($urandom), 32'($urandom)};
         mem_data = {32'($urandom), 32'($urandom)};
         cyc();
      end
      idle_inputs();
      repeat (6) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
